pool_window_addr_gen: RTL and testbench

//  Parametrised read-address generator for the pooling stage. It walks a

---
 rtl/pool_pkg.sv | 24 ++
 rtl/win_idx_counter.sv | 69 ++++++
 rtl/pool_window_addr_gen.sv | 139 +++++++++++++
 tb/tb_pool_window_addr_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared state type and sizing helpers for the pooling window address generator
//
// Contents:
//   pool_state_e  FSM states of the address generator (IDLE, RUN, DONE)
//   win_count     number of whole POOL-wide windows along one image dimension
//   cnt_width     register width able to hold 0..n-1, never narrower than 1 bit
package pool_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pool_state_e;

    // Leftover columns/rows that do not fill a whole window are simply dropped.
    function automatic int win_count(input int dim, input int pool);
        return dim / pool;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/win_idx_counter.sv
// rtl/win_idx_counter.sv - nested column/row/channel window index counter
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   clear       synchronous return to window (0,0) of channel 0
//   advance     step to the next window (column fastest, then row, then channel)
//   ch          channel of the current window
//   col_wrap    current window is the last one of its row
//   row_wrap    current window is the last one of its channel
//   last        current window is the final one of the whole scan
module win_idx_counter
    import pool_pkg::*;
#(
    parameter int WIN_PER_ROW = 12,
    parameter int WIN_PER_COL = 12,
    parameter int NUM_CH      = 1,
    parameter int CH_W        = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            advance,
    output logic [CH_W-1:0] ch,
    output logic            col_wrap,
    output logic            row_wrap,
    output logic            last
);

    localparam int COL_W = cnt_width(WIN_PER_ROW);
    localparam int ROW_W = cnt_width(WIN_PER_COL);

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [CH_W-1:0]  ch_q;

    assign col_wrap = (col_q == COL_W'(WIN_PER_ROW - 1));
    assign row_wrap = col_wrap && (row_q == ROW_W'(WIN_PER_COL - 1));
    assign last     = row_wrap && (ch_q == CH_W'(NUM_CH - 1));
    assign ch       = ch_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
            ch_q  <= '0;
        end else if (clear) begin
            col_q <= '0;
            row_q <= '0;
            ch_q  <= '0;
        end else if (advance) begin
            if (last) begin
                // Wrap back to the first window so the next scan starts clean.
                col_q <= '0;
                row_q <= '0;
                ch_q  <= '0;
            end else if (row_wrap) begin
                col_q <= '0;
                row_q <= '0;
                ch_q  <= ch_q + 1'b1;
            end else if (col_wrap) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool_window_addr_gen.sv
// rtl/pool_window_addr_gen.sv - POOL x POOL window read-address generator for the pooling stage
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   start       begin a scan (taken only while idle)
//   abort       synchronous cancel, back to idle without a done pulse
//   out_ready   consumer accepts the presented window
//   out_valid   addr/ch/last are valid
//   addr        POOL*POOL addresses, element k=i*POOL+j at [k*ADDR_W +: ADDR_W]
//   ch          channel of the presented window
//   last        presented window is the final one of the scan
//   busy        generator is not idle
//   done        one-cycle pulse after the final window is transferred
module pool_window_addr_gen
    import pool_pkg::*;
#(
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24,
    parameter int NUM_CH = 1,
    parameter int POOL   = 2,
    parameter int ADDR_W = $clog2(NUM_CH * IMG_W * IMG_H)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [POOL*POOL*ADDR_W-1:0]   addr,
    output logic [$clog2(NUM_CH):0]       ch,
    output logic                          last,
    output logic                          busy,
    output logic                          done
);

    localparam int NK          = POOL * POOL;
    localparam int CH_W        = $clog2(NUM_CH) + 1;
    localparam int WIN_PER_ROW = win_count(IMG_W, POOL);
    localparam int WIN_PER_COL = win_count(IMG_H, POOL);
    localparam int CH_SIZE     = IMG_W * IMG_H;
    localparam int TAIL        = IMG_W - WIN_PER_ROW * POOL;

    // Address increments, all compile-time constants:
    //   next column: +POOL
    //   next row:    skip the remaining POOL-1 lines of the window band plus
    //                the unused tail columns, then +POOL as usual
    //   next chan:   from the last window of a channel to (0,0) of the next
    localparam logic [ADDR_W-1:0] STEP_COL = ADDR_W'(POOL);
    localparam logic [ADDR_W-1:0] STEP_ROW = ADDR_W'((POOL - 1) * IMG_W + TAIL + POOL);
    localparam logic [ADDR_W-1:0] STEP_CH  =
        ADDR_W'(CH_SIZE - (WIN_PER_COL - 1) * POOL * IMG_W - (WIN_PER_ROW - 1) * POOL);

    if (IMG_W < POOL || IMG_H < POOL || POOL < 1 || NUM_CH < 1) begin : g_bad_params
        $error("pool_window_addr_gen: need IMG_W>=POOL, IMG_H>=POOL, POOL>=1, NUM_CH>=1");
    end

    function automatic logic [ADDR_W-1:0] win0_addr(input int k);
        return ADDR_W'((k / POOL) * IMG_W + (k % POOL));
    endfunction

    pool_state_e       state_q, state_d;
    logic              xfer, final_xfer, preset, cnt_clear;
    logic              col_wrap, row_wrap, cnt_last;
    logic [CH_W-1:0]   ch_cnt;
    logic [ADDR_W-1:0] addr_q [NK];
    logic [ADDR_W-1:0] step;

    // abort takes priority over a transfer presented in the same cycle
    assign xfer       = (state_q == RUN) && out_ready && !abort;
    assign final_xfer = xfer && cnt_last;
    assign cnt_clear  = abort || ((state_q == IDLE) && start);
    assign preset     = cnt_clear || final_xfer;

    win_idx_counter #(
        .WIN_PER_ROW (WIN_PER_ROW),
        .WIN_PER_COL (WIN_PER_COL),
        .NUM_CH      (NUM_CH),
        .CH_W        (CH_W)
    ) u_idx (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .advance  (xfer),
        .ch       (ch_cnt),
        .col_wrap (col_wrap),
        .row_wrap (row_wrap),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !abort) state_d = RUN;
            RUN:     if (abort) state_d = IDLE;
                     else if (final_xfer) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        step = STEP_COL;
        if (row_wrap) begin
            step = STEP_CH;
        end else if (col_wrap) begin
            step = STEP_ROW;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NK; k++) addr_q[k] <= win0_addr(k);
        end else if (preset) begin
            for (int k = 0; k < NK; k++) addr_q[k] <= win0_addr(k);
        end else if (xfer) begin
            for (int k = 0; k < NK; k++) addr_q[k] <= addr_q[k] + step;
        end
    end

    always_comb begin
        addr = '0;
        for (int k = 0; k < NK; k++) addr[k*ADDR_W +: ADDR_W] = addr_q[k];
    end

    assign out_valid = (state_q == RUN);
    assign last      = out_valid && cnt_last;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE) && !abort;
    assign ch        = ch_cnt;

endmodule

// File: tb/tb_pool_window_addr_gen.sv
// tb/tb_pool_window_addr_gen.sv - scoreboard bench for pool_window_addr_gen (24x24x1 and 5x5x2 instances)
module tb_pool_window_addr_gen;

    localparam int P    = 2;
    localparam int AW_A = 10;
    localparam int AW_B = 6;
    localparam int IW [2] = '{24, 5};
    localparam int IH [2] = '{24, 5};
    localparam int NC [2] = '{1, 2};

    typedef struct packed {
        logic [3:0][31:0] a;
        logic [31:0]      ch;
        logic             last;
    } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [1:0]        start, abort, ready, valid, last, busy, done;
    logic [4*AW_A-1:0] addr_a;
    logic [4*AW_B-1:0] addr_b;
    logic [0:0]        ch_a;
    logic [1:0]        ch_b;

    pool_window_addr_gen dut_a (
        .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]), .out_ready(ready[0]),
        .out_valid(valid[0]), .addr(addr_a), .ch(ch_a), .last(last[0]), .busy(busy[0]), .done(done[0])
    );

    pool_window_addr_gen #(.IMG_W(5), .IMG_H(5), .NUM_CH(2), .POOL(2)) dut_b (
        .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]), .out_ready(ready[1]),
        .out_valid(valid[1]), .addr(addr_b), .ch(ch_b), .last(last[1]), .busy(busy[1]), .done(done[1])
    );

    int mon_addr [2][4];
    int mon_ch [2];
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            mon_addr[0][k] = int'(addr_a[k*AW_A +: AW_A]);
            mon_addr[1][k] = int'(addr_b[k*AW_B +: AW_B]);
        end
        mon_ch[0] = int'(ch_a);
        mon_ch[1] = int'(ch_b);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    win_t q0[$];
    win_t q1[$];

    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic win_t q_pop(input int d);
        return (d == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    task automatic q_push(input int d, input win_t w);
        if (d == 0) q0.push_back(w);
        else q1.push_back(w);
    endtask

    task automatic q_flush(input int d);
        if (d == 0) q0.delete();
        else q1.delete();
    endtask

    // Reference: every whole window of every channel, row-major, plain arithmetic.
    task automatic push_scan(input int d);
        int   w, h, c, nr, nc;
        win_t e;
        w  = IW[d];
        h  = IH[d];
        c  = NC[d];
        nr = h / P;
        nc = w / P;
        for (int cc = 0; cc < c; cc++)
            for (int r = 0; r < nr; r++)
                for (int col = 0; col < nc; col++) begin
                    for (int i = 0; i < P; i++)
                        for (int j = 0; j < P; j++)
                            e.a[i*P+j] = 32'(cc*w*h + (r*P + i)*w + col*P + j);
                    e.ch   = 32'(cc);
                    e.last = (cc == c-1) && (r == nr-1) && (col == nc-1);
                    q_push(d, e);
                end
    endtask

    // ready: 0 = held low, 1 = held high, 2 = random
    int rdy_mode [2];
    initial begin
        ready = 2'b11;
        forever begin
            @(posedge clk);
            #2;
            for (int d = 0; d < 2; d++)
                ready[d] = (rdy_mode[d] == 1) || (rdy_mode[d] == 2 && $urandom_range(0, 3) != 0);
        end
    end

    int         pop_cnt [2] = '{0, 0};
    int         done_cnt [2] = '{0, 0};
    logic [1:0] hold_v   = '0;
    logic [1:0] done_due = '0;
    win_t       held [2];
    win_t       cur, exp_w;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                hold_v[d]   = 1'b0;
                done_due[d] = 1'b0;
            end else begin
                if (done[d]) done_cnt[d]++;
                if (done_due[d]) begin
                    check("done_pulse", int'(done[d]), 1);
                    check("valid_after_last", int'(valid[d]), 0);
                    done_due[d] = 1'b0;
                end
                if (valid[d]) begin
                    for (int k = 0; k < 4; k++) cur.a[k] = 32'(mon_addr[d][k]);
                    cur.ch   = 32'(mon_ch[d]);
                    cur.last = last[d];
                    if (hold_v[d]) check("stall_stable", int'(cur == held[d]), 1);
                    if (ready[d]) begin
                        if (q_size(d) == 0) begin
                            check("unexpected_window", 1, 0);
                        end else begin
                            exp_w = q_pop(d);
                            for (int k = 0; k < 4; k++) check("win_addr", int'(cur.a[k]), int'(exp_w.a[k]));
                            check("win_ch", int'(cur.ch), int'(exp_w.ch));
                            check("win_last", int'(cur.last), int'(exp_w.last));
                            pop_cnt[d]++;
                            if (exp_w.last) done_due[d] = 1'b1;
                        end
                        hold_v[d] = 1'b0;
                    end else begin
                        hold_v[d] = 1'b1;
                        held[d]   = cur;
                    end
                end else begin
                    hold_v[d] = 1'b0;
                end
            end
        end
    end

    task automatic reset_checks(input int d);
        check("rst_valid", int'(valid[d]), 0);
        check("rst_busy", int'(busy[d]), 0);
        check("rst_done", int'(done[d]), 0);
        check("rst_last", int'(last[d]), 0);
        check("rst_ch", mon_ch[d], 0);
        for (int k = 0; k < 4; k++) check("rst_addr", mon_addr[d][k], (k / P) * IW[d] + (k % P));
    endtask

    task automatic pulse_start(input int d);
        @(posedge clk);
        #1 start[d] = 1'b1;
        @(posedge clk);
        #1 start[d] = 1'b0;
        check("start_latency", int'(valid[d]), 1);
        check("busy_run", int'(busy[d]), 1);
    endtask

    task automatic run_scan(input int d, input int mode, input bit stall, input bit poke);
        int p0, dc0, cyc, stall_left;
        bit stalled;
        p0         = pop_cnt[d];
        dc0        = done_cnt[d];
        stall_left = 0;
        stalled    = 1'b0;
        rdy_mode[d] = mode;
        push_scan(d);
        pulse_start(d);
        cyc = 0;
        while ((q_size(d) != 0 || done_due[d]) && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            start[d] = poke && (cyc == 3);
            if (stall && !stalled && (pop_cnt[d] - p0 == 1)) begin
                rdy_mode[d] = 0;
                stall_left  = 5;
                stalled     = 1'b1;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) rdy_mode[d] = mode;
            end
        end
        start[d] = 1'b0;
        check("scan_drained", q_size(d), 0);
        check("busy_after_done", int'(busy[d]), 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", done_cnt[d] - dc0, 1);
        check("idle_valid", int'(valid[d]), 0);
    endtask

    task automatic abort_test(input int d);
        int p0, dc0, cyc;
        p0  = pop_cnt[d];
        dc0 = done_cnt[d];
        rdy_mode[d] = 2;
        push_scan(d);
        pulse_start(d);
        cyc = 0;
        while (pop_cnt[d] - p0 < 2 && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("abort_reach_win3", pop_cnt[d] - p0, 2);
        rdy_mode[d] = 0;
        abort[d]    = 1'b1;
        @(posedge clk);
        #1 abort[d] = 1'b0;
        check("abort_valid", int'(valid[d]), 0);
        check("abort_busy", int'(busy[d]), 0);
        check("abort_last", int'(last[d]), 0);
        q_flush(d);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt[d] - dc0, 0);
        check("abort_addr0", mon_addr[d][0], 0);
        check("abort_ch0", mon_ch[d], 0);
        rdy_mode[d] = 1;
    endtask

    initial begin
        int p0, cyc;
        reset    = 1'b1;
        start    = '0;
        abort    = '0;
        rdy_mode = '{1, 1};
        repeat (2) @(posedge clk);
        #1;
        reset_checks(0);
        reset_checks(1);
        reset = 1'b0;

        run_scan(1, 1, 1'b0, 1'b0);
        run_scan(1, 1, 1'b1, 1'b1);
        run_scan(0, 2, 1'b0, 1'b0);
        abort_test(0);
        run_scan(0, 1, 1'b0, 1'b0);

        // start together with abort while idle: abort wins
        @(posedge clk);
        #1 start[1] = 1'b1;
        abort[1] = 1'b1;
        @(posedge clk);
        #1 start[1] = 1'b0;
        abort[1] = 1'b0;
        check("start_abort_idle", int'(busy[1]), 0);

        // asynchronous reset in the middle of a scan
        rdy_mode[1] = 2;
        push_scan(1);
        pulse_start(1);
        p0  = pop_cnt[1];
        cyc = 0;
        while (pop_cnt[1] - p0 < 3 && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("midscan_reach", pop_cnt[1] - p0, 3);
        #2 reset = 1'b1;
        #1;
        reset_checks(1);
        q_flush(1);
        @(posedge clk);
        #1 reset = 1'b0;
        run_scan(1, 2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
